// File: rtl/uart_ornekli_alici.sv
// uart_ornekli_alici: oversampling UART receive front-end.
//   Synchronises the raw rx line, detects the start bit, majority-votes each bit near its centre,
//   checks optional parity and the stop bit, and presents bytes on a valid/ready port.
// Ports:
//   clk_i, rstn_i       clock, asynchronous active-low reset
//   en_i                receiver enable; low aborts any frame in progress
//   baud_div_i          clock cycles per bit (values below 8 are treated as 8)
//   rx_i                raw serial line, idle high, asynchronous to clk_i
//   veri_o, gecerli_o   received byte and its valid flag (held until hazir_i)
//   hazir_i             consumer ready
//   mesgul_o            receiver is inside a frame
//   cerceve_hata_o      1-cycle pulse: stop bit sampled low
//   parite_hata_o       1-cycle pulse: parity mismatch
//   tasma_hata_o        1-cycle pulse: frame completed while previous byte still pending
module uart_ornekli_alici #(
  parameter int unsigned VERI_BIT_SAYISI = 8,
  parameter int unsigned PARITE          = 0,
  parameter int unsigned SENK_KATMAN     = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  input  logic [15:0] baud_div_i,
  input  logic        rx_i,
  output logic [7:0]  veri_o,
  output logic        gecerli_o,
  input  logic        hazir_i,
  output logic        mesgul_o,
  output logic        cerceve_hata_o,
  output logic        parite_hata_o,
  output logic        tasma_hata_o
);

  typedef enum logic [2:0] {StBosta, StBasla, StVeri, StParite, StDur} durum_e;

  localparam logic [2:0] SonBit = 3'(VERI_BIT_SAYISI - 1);

  durum_e durum_q, durum_d;
  logic [SENK_KATMAN-1:0] senk_q;
  logic [1:0]  gecmis_q;
  logic [15:0] sayac_q, sayac_d;
  logic [15:0] div_r_q, div_r_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tampon_q, tampon_d;
  logic        parite_bozuk_q, parite_bozuk_d;
  logic        bos_gordu_q, bos_gordu_d;
  logic [7:0]  veri_q, veri_d;
  logic        gecerli_q, gecerli_d;
  logic        cerceve_q, cerceve_d;
  logic        parite_q, parite_d;
  logic        tasma_q, tasma_d;

  logic        rx_s, oy, beklenen_parite, orta_nokta, son_ornek;
  logic [15:0] div_etkin;

  assign rx_s = senk_q[SENK_KATMAN-1];
  // 2-of-3 vote over the current and two previous synchronised samples rejects single-cycle spikes.
  assign oy   = (rx_s & gecmis_q[0]) | (rx_s & gecmis_q[1]) | (gecmis_q[0] & gecmis_q[1]);

  assign div_etkin  = (baud_div_i < 16'd8) ? 16'd8 : baud_div_i;
  assign orta_nokta = (sayac_q == {1'b0, div_r_q[15:1]});
  assign son_ornek  = (sayac_q == div_r_q - 16'd1);
  // Unused upper buffer bits stay 0, so reducing over all 8 bits is safe for narrow frames.
  assign beklenen_parite = (PARITE == 2) ? ~(^tampon_q) : (^tampon_q);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      senk_q   <= '1;
      gecmis_q <= 2'b11;
    end else begin
      if (SENK_KATMAN > 1) begin
        senk_q <= {senk_q[SENK_KATMAN-2:0], rx_i};
      end else begin
        senk_q <= rx_i;
      end
      gecmis_q <= {gecmis_q[0], rx_s};
    end
  end

  always_comb begin
    durum_d        = durum_q;
    sayac_d        = sayac_q;
    div_r_d        = div_r_q;
    bit_d          = bit_q;
    tampon_d       = tampon_q;
    parite_bozuk_d = parite_bozuk_q;
    bos_gordu_d    = bos_gordu_q;
    veri_d         = veri_q;
    gecerli_d      = gecerli_q;
    cerceve_d      = 1'b0;
    parite_d       = 1'b0;
    tasma_d        = 1'b0;

    if (gecerli_q && hazir_i) begin
      gecerli_d = 1'b0;
    end

    if (!en_i) begin
      durum_d     = StBosta;
      bos_gordu_d = 1'b0;
    end else begin
      unique case (durum_q)
        StBosta: begin
          if (rx_s) begin
            bos_gordu_d = 1'b1;
          end else if (bos_gordu_q) begin
            durum_d        = StBasla;
            sayac_d        = '0;
            div_r_d        = div_etkin;
            tampon_d       = '0;
            parite_bozuk_d = 1'b0;
          end
        end
        StBasla: begin
          if (orta_nokta) begin
            sayac_d = '0;
            bit_d   = '0;
            durum_d = oy ? StBosta : StVeri;
          end else begin
            sayac_d = sayac_q + 16'd1;
          end
        end
        StVeri: begin
          if (son_ornek) begin
            sayac_d         = '0;
            tampon_d[bit_q] = oy;
            if (bit_q == SonBit) begin
              durum_d = (PARITE != 0) ? StParite : StDur;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            sayac_d = sayac_q + 16'd1;
          end
        end
        StParite: begin
          if (son_ornek) begin
            sayac_d        = '0;
            parite_bozuk_d = (oy != beklenen_parite);
            durum_d        = StDur;
          end else begin
            sayac_d = sayac_q + 16'd1;
          end
        end
        StDur: begin
          if (son_ornek) begin
            sayac_d     = '0;
            durum_d     = StBosta;
            bos_gordu_d = oy;
            // Framing beats parity beats overrun; a same-cycle accept frees the slot for the new byte.
            if (!oy) begin
              cerceve_d = 1'b1;
            end else if (parite_bozuk_q) begin
              parite_d = 1'b1;
            end else if (gecerli_q && !hazir_i) begin
              tasma_d = 1'b1;
            end else begin
              veri_d    = tampon_q;
              gecerli_d = 1'b1;
            end
          end else begin
            sayac_d = sayac_q + 16'd1;
          end
        end
        default: durum_d = StBosta;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q        <= StBosta;
      sayac_q        <= '0;
      div_r_q        <= 16'd8;
      bit_q          <= '0;
      tampon_q       <= '0;
      parite_bozuk_q <= 1'b0;
      bos_gordu_q    <= 1'b0;
      veri_q         <= '0;
      gecerli_q      <= 1'b0;
      cerceve_q      <= 1'b0;
      parite_q       <= 1'b0;
      tasma_q        <= 1'b0;
    end else begin
      durum_q        <= durum_d;
      sayac_q        <= sayac_d;
      div_r_q        <= div_r_d;
      bit_q          <= bit_d;
      tampon_q       <= tampon_d;
      parite_bozuk_q <= parite_bozuk_d;
      bos_gordu_q    <= bos_gordu_d;
      veri_q         <= veri_d;
      gecerli_q      <= gecerli_d;
      cerceve_q      <= cerceve_d;
      parite_q       <= parite_d;
      tasma_q        <= tasma_d;
    end
  end

  assign veri_o         = veri_q;
  assign gecerli_o      = gecerli_q;
  assign mesgul_o       = (durum_q != StBosta);
  assign cerceve_hata_o = cerceve_q;
  assign parite_hata_o  = parite_q;
  assign tasma_hata_o   = tasma_q;

endmodule
